// File: rtl/draw_player_if.sv
// Pixel-stream bundle between draw_background, draw_player, the sprite ROM and the VGA pins.
// The slave modport is the compositor's view; master is the driving environment.
interface draw_player_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic [10:0]       vcount_in;
   logic              vsync_in;
   logic              vblnk_in;
   logic [10:0]       hcount_in;
   logic              hsync_in;
   logic              hblnk_in;
   logic [11:0]       rgb_in;
   logic [10:0]       xpos;
   logic [10:0]       ypos;
   logic              mirror;
   logic [11:0]       rgb_pixel;
   logic [ADDR_W-1:0] pixel_addr;
   logic [10:0]       vcount_out;
   logic              vsync_out;
   logic              vblnk_out;
   logic [10:0]       hcount_out;
   logic              hsync_out;
   logic              hblnk_out;
   logic [11:0]       rgb_out;

   modport master (
      output vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in,
      output xpos, ypos, mirror, rgb_pixel,
      input  pixel_addr, vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out,
      input  rgb_out
   );

   modport slave (
      input  vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in,
      input  xpos, ypos, mirror, rgb_pixel,
      output pixel_addr, vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out,
      output rgb_out
   );
endinterface

// File: rtl/draw_player.sv
// Two-stage sprite compositor: stage 1 issues the ROM address, stage 2 keys out the
// transparent colour. Sprite position is latched at each vblank rising edge.
module draw_player #(
   parameter int unsigned SPRITE_W    = 32,
   parameter int unsigned SPRITE_H    = 32,
   parameter int unsigned ADDR_W      = 10,
   parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
   input  logic         pclk,
   input  logic         rst,
   draw_player_if.slave bus_io
);
   localparam int unsigned XW = $clog2(SPRITE_W);
   localparam int unsigned YW = $clog2(SPRITE_H);

   typedef struct packed {
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
   } timing_t;

   timing_t           tim_in, tim1_q, tim2_q;
   logic              vblnk_prev_q;
   logic [10:0]       xpos_q, xpos_d, ypos_q, ypos_d;
   logic              mirror_q, mirror_d;
   logic              in_box_q, in_box_d;
   logic [11:0]       rgb1_q;
   logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
   logic [11:0]       rgb_out_q, rgb_out_d;
   logic              frame_start, h_hit, v_hit;
   logic [XW-1:0]     dx, col;
   logic [YW-1:0]     dy;

   always_comb begin
      tim_in = {bus_io.vcount_in, bus_io.vsync_in, bus_io.vblnk_in,
                bus_io.hcount_in, bus_io.hsync_in, bus_io.hblnk_in};

      frame_start = bus_io.vblnk_in && !vblnk_prev_q;
      xpos_d      = frame_start ? bus_io.xpos   : xpos_q;
      ypos_d      = frame_start ? bus_io.ypos   : ypos_q;
      mirror_d    = frame_start ? bus_io.mirror : mirror_q;

      // Only the low bits of the offsets reach the ROM address.
      dx  = bus_io.hcount_in[XW-1:0] - xpos_q[XW-1:0];
      dy  = bus_io.vcount_in[YW-1:0] - ypos_q[YW-1:0];
      col = mirror_q ? ~dx : dx;
      pixel_addr_d = ADDR_W'({dy, col});

      // 12-bit upper bound so a sprite near 2047 cannot wrap onto column 0.
      h_hit = (bus_io.hcount_in >= xpos_q) &&
              ({1'b0, bus_io.hcount_in} < ({1'b0, xpos_q} + 12'(SPRITE_W)));
      v_hit = (bus_io.vcount_in >= ypos_q) &&
              ({1'b0, bus_io.vcount_in} < ({1'b0, ypos_q} + 12'(SPRITE_H)));
      in_box_d = h_hit && v_hit && !bus_io.hblnk_in && !bus_io.vblnk_in;

      rgb_out_d = rgb1_q;
      if (tim1_q.hblnk || tim1_q.vblnk) begin
         rgb_out_d = 12'h000;
      end else if (in_box_q && (bus_io.rgb_pixel != TRANSPARENT)) begin
         rgb_out_d = bus_io.rgb_pixel;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         vblnk_prev_q <= 1'b0;
         xpos_q       <= '0;
         ypos_q       <= '0;
         mirror_q     <= 1'b0;
         tim1_q       <= '0;
         tim2_q       <= '0;
         in_box_q     <= 1'b0;
         rgb1_q       <= '0;
         pixel_addr_q <= '0;
         rgb_out_q    <= '0;
      end else begin
         vblnk_prev_q <= bus_io.vblnk_in;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         mirror_q     <= mirror_d;
         tim1_q       <= tim_in;
         tim2_q       <= tim1_q;
         in_box_q     <= in_box_d;
         rgb1_q       <= bus_io.rgb_in;
         pixel_addr_q <= pixel_addr_d;
         rgb_out_q    <= rgb_out_d;
      end
   end

   assign bus_io.pixel_addr = pixel_addr_q;
   assign bus_io.vcount_out = tim2_q.vcount;
   assign bus_io.vsync_out  = tim2_q.vsync;
   assign bus_io.vblnk_out  = tim2_q.vblnk;
   assign bus_io.hcount_out = tim2_q.hcount;
   assign bus_io.hsync_out  = tim2_q.hsync;
   assign bus_io.hblnk_out  = tim2_q.hblnk;
   assign bus_io.rgb_out    = rgb_out_q;
endmodule

// File: tb/tb_draw_player.sv
// Randomised bench for draw_player: a per-pixel screen-space model predicts the composited
// colour, ROM address and 2-cycle-delayed timing for every driven pixel.
module tb_draw_player;
   logic pclk = 1'b0;
   logic rst;

   always #5 pclk = ~pclk;

   draw_player_if #(.ADDR_W(10)) bus ();

   draw_player #(
      .SPRITE_W   (32),
      .SPRITE_H   (32),
      .ADDR_W     (10),
      .TRANSPARENT(12'hF0F)
   ) dut (
      .pclk  (pclk),
      .rst   (rst),
      .bus_io(bus)
   );

   logic [11:0] rom_mem [1024];
   // Address is already registered in the DUT, so data appears one cycle after issue.
   assign bus.rgb_pixel = rom_mem[bus.pixel_addr];

   typedef struct {
      bit          valid;
      bit          chk_addr;
      logic [9:0]  addr;
      logic [11:0] rgb;
      logic [25:0] tim;
   } exp_t;

   exp_t r1, r2;
   int   n_vec, n_err;
   int   m_x, m_y;
   bit   m_m, m_prev;
   int   cur_x, cur_y;
   bit   cur_m;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int h, input int v, input bit hb, input bit vb, input bit r);
      exp_t        nw;
      logic [11:0] rgb, d;
      bit          hs, vs;
      int          dx, dy, addr;
      @(negedge pclk);
      if (r1.valid && r1.chk_addr) check_val("pixel_addr", 32'(bus.pixel_addr), 32'(r1.addr));
      if (r2.valid) begin
         check_val("rgb_out", 32'(bus.rgb_out), 32'(r2.rgb));
         check_val("timing", 32'({bus.vcount_out, bus.vsync_out, bus.vblnk_out,
                                  bus.hcount_out, bus.hsync_out, bus.hblnk_out}), 32'(r2.tim));
      end
      rgb = 12'($urandom);
      hs  = 1'($urandom);
      vs  = 1'($urandom);
      rst           = r;
      bus.hcount_in = 11'(h);
      bus.vcount_in = 11'(v);
      bus.hblnk_in  = hb;
      bus.vblnk_in  = vb;
      bus.hsync_in  = hs;
      bus.vsync_in  = vs;
      bus.rgb_in    = rgb;
      bus.xpos      = 11'(cur_x);
      bus.ypos      = 11'(cur_y);
      bus.mirror    = cur_m;
      nw.valid    = 1'b1;
      nw.chk_addr = 1'b0;
      nw.addr     = '0;
      nw.tim      = {11'(v), vs, vb, 11'(h), hs, hb};
      if (r) begin
         nw.rgb   = '0;
         nw.tim   = '0;
         r1.valid = 1'b1;
         r1.rgb   = '0;
         r1.tim   = '0;
         m_x = 0; m_y = 0; m_m = 1'b0; m_prev = 1'b0;
      end else begin
         if (hb || vb) begin
            nw.rgb = '0;
         end else if (h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32) begin
            dx   = h - m_x;
            dy   = v - m_y;
            addr = dy * 32 + (m_m ? 31 - dx : dx);
            d    = rom_mem[addr];
            nw.chk_addr = 1'b1;
            nw.addr     = 10'(addr);
            nw.rgb      = (d != 12'hF0F) ? d : rgb;
         end else begin
            nw.rgb = rgb;
         end
         if (vb && !m_prev) begin
            m_x = cur_x; m_y = cur_y; m_m = cur_m;
         end
         m_prev = vb;
      end
      r2 = r1;
      r1 = nw;
   endtask

   task automatic px(input int h, input int v);
      tick(h, v, h >= 1280, v >= 1024, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1300, 500, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic vblank();
      tick(1300, 1023, 1'b1, 1'b0, 1'b0);
      repeat (3) tick(10, 1025, 1'b0, 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic region(input int v0, input int v1, input int h0, input int h1);
      for (int v = v0; v <= v1; v++)
         for (int h = h0; h <= h1; h++) px(h, v);
   endtask

   task automatic rom_fill(input bit rnd);
      int k;
      idle(3);
      for (int i = 0; i < 1024; i++) begin
         k = int'($urandom_range(0, 19));
         if (!rnd)        rom_mem[i] = 12'(i);
         else if (k < 5)  rom_mem[i] = 12'hF0F;
         else if (k < 7)  rom_mem[i] = 12'hF00;
         else             rom_mem[i] = 12'($urandom);
      end
   endtask

   initial begin
      int h, v;
      bit hb, vb, r;
      n_vec = 0; n_err = 0;
      r1.valid = 1'b0; r2.valid = 1'b0;
      cur_x = 0; cur_y = 0; cur_m = 1'b0;
      m_x = 0; m_y = 0; m_m = 1'b0; m_prev = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) rom_mem[i] = 12'(i);

      // Reset with live inputs, then plain tracking with the sprite parked at (0,0).
      repeat (3) tick(int'($urandom_range(0, 1279)), int'($urandom_range(0, 1023)), 0, 0, 1);
      repeat (40) px(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));

      // Sprite at (100,200), ROM data = address.
      cur_x = 100; cur_y = 200; cur_m = 1'b0;
      vblank();
      region(198, 233, 97, 135);

      // Transparent and opaque ROM colours.
      rom_fill(1'b1);
      region(198, 233, 97, 135);

      // Mirrored sprite.
      cur_m = 1'b1;
      vblank();
      region(198, 233, 97, 135);
      rom_fill(1'b0);
      region(199, 202, 98, 134);

      // Mid-frame position change waits for the next vblank edge.
      cur_m = 1'b0; cur_x = 100; cur_y = 290;
      vblank();
      region(295, 299, 95, 140);
      cur_x = 500;
      region(300, 304, 95, 140);
      region(300, 304, 495, 540);
      vblank();
      region(295, 299, 95, 140);
      region(295, 299, 495, 540);

      // Right-edge clipping and no wrap near 2047.
      cur_x = 1270; cur_y = 200;
      vblank();
      for (int y = 200; y <= 203; y++) begin
         region(y, y, 1265, 1300);
         region(y + 1, y + 1, 0, 25);
      end
      cur_x = 2040;
      vblank();
      region(200, 203, 2030, 2047);
      region(200, 203, 0, 35);

      // Bottom-right corner against both blanking regions.
      cur_x = 1260; cur_y = 1010;
      vblank();
      region(1015, 1030, 1255, 1300);

      // Random pixels, positions, blanking and occasional reset.
      rom_fill(1'b1);
      repeat (3000) begin
         if ($urandom_range(0, 99) == 0) begin
            cur_x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047))
                                                 : int'($urandom_range(0, 1300));
            cur_y = int'($urandom_range(0, 1040));
            cur_m = 1'($urandom);
         end
         h  = (m_x + int'($urandom_range(0, 40)) - 4) & 2047;
         v  = (m_y + int'($urandom_range(0, 40)) - 4) & 2047;
         hb = (h >= 1280) || ($urandom_range(0, 19) == 0);
         vb = (v >= 1024) || ($urandom_range(0, 49) == 0);
         r  = ($urandom_range(0, 299) == 0);
         tick(h, v, hb, vb, r);
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
